// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (checksum byte, CHK/ERR states, sticky err).
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         RAM_AW    = 8;
    localparam int         WORD_W    = 16;

    // CHK and ERR are only reachable when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [3:0] {
        StSync,
        StPc,
        StCnt,
        StHi,
        StLo,
        StWr,
        StChk,
        StRun,
        StErr
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses A5/PC/COUNT/words frames, writes 16-bit words to RAM,
// holds the CPU in reset while loading and hands the RAM port back to the CPU in RUN.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte, the CHK and
// ERR states and a sticky err output; without it err is tied low.
module prog_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    input  logic              cpu_ram_w_en,
    input  logic [RAM_AW-1:0] cpu_ram_addr,
    input  logic [WORD_W-1:0] cpu_ram_w_data,
    output logic              ram_w_en,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_w_data,
    output logic [7:0]        start_pc,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              err
);

    loader_state_t     state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [7:0]        start_pc_q, start_pc_d;
    logic [8:0]        remain_q, remain_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic              w_en_q;
    logic              cpu_rst_n_q;
    logic              accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
    logic              err_q, err_d;
`endif

    assign accept = in_valid & in_ready;

    // Level outputs decoded from the current state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            StSync:                    in_ready = 1'b1;
            StPc, StCnt, StHi, StLo:   begin in_ready = 1'b1; busy = 1'b1; end
            StChk:                     begin in_ready = 1'b1; busy = 1'b1; end
            StWr:                      busy = 1'b1;
            default:                   ;
        endcase
    end

    // Frame parser next-state; reload overrides everything else.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        start_pc_d = start_pc_q;
        remain_d   = remain_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            StSync: begin
                if (accept && in_data == SYNC_BYTE) state_d = StPc;
            end
            StPc: begin
                if (accept) begin
                    start_pc_d = in_data;
                    addr_d     = in_data;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = in_data;
`endif
                    state_d    = StCnt;
                end
            end
            StCnt: begin
                if (accept) begin
                    // COUNT of zero encodes a full 256-word image.
                    remain_d = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
`ifdef LOADER_CHECKSUM_EN
                    xor_d    = xor_q ^ in_data;
`endif
                    state_d  = StHi;
                end
            end
            StHi: begin
                if (accept) begin
                    hi_d    = in_data;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ in_data;
`endif
                    state_d = StLo;
                end
            end
            StLo: begin
                if (accept) begin
                    lo_d    = in_data;
`ifdef LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ in_data;
`endif
                    state_d = StWr;
                end
            end
            StWr: begin
                addr_d   = addr_q + 8'd1;
                remain_d = remain_q - 9'd1;
                if (remain_d != 9'd0) begin
                    state_d = StHi;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StRun;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d = StRun;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            StErr:   ;
`endif
            StRun:   ;
            default: state_d = StSync;
        endcase

        if (reload) begin
            state_d  = StSync;
            remain_d = 9'd0;
            hi_d     = 8'h00;
            lo_d     = 8'h00;
`ifdef LOADER_CHECKSUM_EN
            xor_d    = 8'h00;
            err_d    = 1'b0;
`endif
        end
    end

    // State and datapath registers; write strobe and CPU release are registered from state_d
    // so neither can glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSync;
            addr_q      <= '0;
            start_pc_q  <= 8'h00;
            remain_q    <= 9'd0;
            hi_q        <= 8'h00;
            lo_q        <= 8'h00;
            w_en_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= 8'h00;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            start_pc_q  <= start_pc_d;
            remain_q    <= remain_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            w_en_q      <= (state_d == StWr);
            cpu_rst_n_q <= (state_d == StRun);
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
            err_q       <= err_d;
`endif
        end
    end

    // RAM port steering: CPU owns it only in RUN.
    always_comb begin
        if (state_q == StRun) begin
            ram_w_en   = cpu_ram_w_en;
            ram_addr   = cpu_ram_addr;
            ram_w_data = cpu_ram_w_data;
        end else begin
            ram_w_en   = w_en_q;
            ram_addr   = addr_q;
            ram_w_data = {hi_q, lo_q};
        end
    end

    assign start_pc  = start_pc_q;
    assign cpu_rst_n = cpu_rst_n_q;
`ifdef LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of fixed frames, hand-written timing/reload/reset
// sequences, and random frames checked against a stream-level reference model.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        cpu_ram_w_en = 1'b0;
    logic [7:0]  cpu_ram_addr = 8'h00;
    logic [15:0] cpu_ram_w_data = 16'h0000;
    logic        ram_w_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_w_data;
    logic [7:0]  start_pc;
    logic        cpu_rst_n;
    logic        busy;
    logic        err;

    prog_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .reload         (reload),
        .cpu_ram_w_en   (cpu_ram_w_en),
        .cpu_ram_addr   (cpu_ram_addr),
        .cpu_ram_w_data (cpu_ram_w_data),
        .ram_w_en       (ram_w_en),
        .ram_addr       (ram_addr),
        .ram_w_data     (ram_w_data),
        .start_pc       (start_pc),
        .cpu_rst_n      (cpu_rst_n),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [11:0][7:0] b;   // stream bytes, first byte in the most significant used slot
        logic [7:0]       len;
        logic [7:0]       chk;
        logic [7:0]       pc;
        logic [1:0]       nw;
        logic [1:0][7:0]  ea;
        logic [1:0][15:0] ed;
        logic             bub;
    } vec_t;

    vec_t vecs[4];

    // Loader writes observed while the CPU is held in reset.
    logic [7:0]  log_a[$];
    logic [15:0] log_d[$];

    always @(negedge clk) begin
        if (rst_n && ram_w_en && !cpu_rst_n) begin
            log_a.push_back(ram_addr);
            log_d.push_back(ram_w_data);
        end
    end

    // Reference model results.
    logic [7:0]  m_a[$];
    logic [15:0] m_d[$];
    logic [7:0]  m_pc;

    task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bub);
        bit done = 0;
        if (bub && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) step();
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready) done = 1;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL byte_accept_timeout: byte %0h not accepted in 50 cycles", b);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    task automatic send_vec(input vec_t v);
        for (int i = 0; i < int'(v.len); i++) send_byte(v.b[int'(v.len) - 1 - i], v.bub);
`ifdef LOADER_CHECKSUM_EN
        send_byte(v.chk, v.bub);
`endif
    endtask

    task automatic send_stream(input bq_t s, input logic bub);
        foreach (s[i]) send_byte(s[i], bub);
    endtask

    // Frame-level model: hunt for sync, read PC and COUNT, then COUNT big-endian words
    // written to consecutive addresses modulo 256.
    function automatic void model_run(input bq_t s);
        int i = 0;
        int n;
        m_a.delete();
        m_d.delete();
        while (i < s.size() && s[i] != 8'hA5) i++;
        if (i + 2 >= s.size()) return;
        m_pc = s[i + 1];
        n    = (s[i + 2] == 8'h00) ? 256 : int'(s[i + 2]);
        i   += 3;
        for (int w = 0; w < n && i + 1 < s.size(); w++) begin
            m_a.push_back(8'((int'(m_pc) + w) % 256));
            m_d.push_back({s[i], s[i + 1]});
            i += 2;
        end
    endfunction

    function automatic logic [7:0] xor_sum(input bq_t s, input int from);
        logic [7:0] x = 8'h00;
        for (int i = from; i < s.size(); i++) x ^= s[i];
        return x;
    endfunction

    function automatic vec_t mk(input logic [95:0] b, input int len, input logic [7:0] chk,
                                input logic [7:0] pc, input int nw, input logic [7:0] a0,
                                input logic [7:0] a1, input logic [15:0] d0,
                                input logic [15:0] d1, input logic bub);
        vec_t v;
        v.b   = b;
        v.len = 8'(len);
        v.chk = chk;
        v.pc  = pc;
        v.nw  = 2'(nw);
        v.ea  = {a1, a0};
        v.ed  = {d1, d0};
        v.bub = bub;
        return v;
    endfunction

    task automatic check_model(input string tag);
        chk_eq({tag, "_nwrites"}, log_a.size(), m_a.size());
        for (int k = 0; k < m_a.size() && k < log_a.size(); k++) begin
            chk_eq({tag, "_addr"}, log_a[k], m_a[k]);
            chk_eq({tag, "_data"}, log_d[k], m_d[k]);
        end
        chk_eq({tag, "_start_pc"}, start_pc, m_pc);
        chk_eq({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b1);
    endtask

    initial begin
        bq_t s;
        int  cnt;
        int  bad;
        int  seen[256];
        vec_t v;

        vecs[0] = mk(96'hA5_10_02_12_34_AB_CD, 7, 8'h52, 8'h10, 2, 8'h10, 8'h11,
                     16'h1234, 16'hABCD, 1'b0);
        vecs[1] = mk(96'hA5_FF_02_00_01_00_02, 7, 8'hFE, 8'hFF, 2, 8'hFF, 8'h00,
                     16'h0001, 16'h0002, 1'b0);
        vecs[2] = mk(96'h00_FF_5A_A5_10_02_12_34_AB_CD, 10, 8'h52, 8'h10, 2, 8'h10, 8'h11,
                     16'h1234, 16'hABCD, 1'b1);
        vecs[3] = mk(96'hA5_3C_01_BE_EF, 5, 8'h6C, 8'h3C, 1, 8'h3C, 8'h00,
                     16'hBEEF, 16'h0000, 1'b1);

        // Reset values.
        repeat (3) @(negedge clk);
        chk_eq("rst_start_pc", start_pc, 8'h00);
        chk_eq("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        chk_eq("rst_err", err, 1'b0);
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_ram_w_en", ram_w_en, 1'b0);
        rst_n = 1'b1;
        step();
        chk_eq("rst_in_ready", in_ready, 1'b1);

        // Table frames, with the CPU trying to write throughout to exercise steering.
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            cpu_ram_w_en   = 1'b1;
            cpu_ram_addr   = 8'h77;
            cpu_ram_w_data = 16'hDEAD;
            pulse_reload();
            log_a.delete();
            log_d.delete();
            send_vec(v);
            cpu_ram_w_en = 1'b0;
            repeat (3) step();
            chk_eq($sformatf("vec%0d_nwrites", i), log_a.size(), int'(v.nw));
            for (int k = 0; k < int'(v.nw) && k < log_a.size(); k++) begin
                chk_eq($sformatf("vec%0d_addr%0d", i, k), log_a[k], v.ea[k]);
                chk_eq($sformatf("vec%0d_data%0d", i, k), log_d[k], v.ed[k]);
            end
            chk_eq($sformatf("vec%0d_start_pc", i), start_pc, v.pc);
            chk_eq($sformatf("vec%0d_cpu_rst_n", i), cpu_rst_n, 1'b1);
            chk_eq($sformatf("vec%0d_err", i), err, 1'b0);
            chk_eq($sformatf("vec%0d_in_ready", i), in_ready, 1'b0);
            chk_eq($sformatf("vec%0d_busy", i), busy, 1'b0);
        end

        // Write latency and release point.
        pulse_reload();
        log_a.delete();
        log_d.delete();
        s = '{8'hA5, 8'h20, 8'h01, 8'hCA, 8'hFE};
        send_stream(s, 1'b0);
        chk_eq("lat_w_en", ram_w_en, 1'b1);
        chk_eq("lat_addr", ram_addr, 8'h20);
        chk_eq("lat_data", ram_w_data, 16'hCAFE);
        chk_eq("lat_cpu_held", cpu_rst_n, 1'b0);
        chk_eq("lat_in_ready_wr", in_ready, 1'b0);
        step();
`ifdef LOADER_CHECKSUM_EN
        chk_eq("chk_cpu_held", cpu_rst_n, 1'b0);
        chk_eq("chk_w_en", ram_w_en, 1'b0);
        chk_eq("chk_in_ready", in_ready, 1'b1);
        send_byte(8'h15, 1'b0);
`endif
        chk_eq("release_cpu_rst_n", cpu_rst_n, 1'b1);
        chk_eq("release_w_en", ram_w_en, 1'b0);

        // RUN passthrough.
        for (int k = 0; k < 3; k++) begin
            logic [7:0]  pa;
            logic [15:0] pd;
            logic        pw;
            pa = 8'($urandom);
            pd = 16'($urandom);
            pw = 1'($urandom);
            cpu_ram_w_en   = pw;
            cpu_ram_addr   = pa;
            cpu_ram_w_data = pd;
            #1;
            chk_eq("pass_w_en", ram_w_en, pw);
            chk_eq("pass_addr", ram_addr, pa);
            chk_eq("pass_data", ram_w_data, pd);
        end
        cpu_ram_w_en = 1'b0;

        // COUNT=0: full 256-word image.
        pulse_reload();
        log_a.delete();
        log_d.delete();
        s = '{8'hA5, 8'($urandom), 8'h00};
        for (int k = 0; k < 512; k++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        s.push_back(xor_sum(s, 1));
`endif
        send_stream(s, 1'b0);
        repeat (2) step();
        model_run(s);
        check_model("cnt0");
        foreach (seen[k]) seen[k] = 0;
        foreach (log_a[k]) seen[log_a[k]]++;
        bad = 0;
        foreach (seen[k]) if (seen[k] != 1) bad++;
        chk_eq("cnt0_addr_once", bad, 0);

        // Random frames with garbage before sync and valid bubbles.
        for (int it = 0; it < 6; it++) begin
            pulse_reload();
            log_a.delete();
            log_d.delete();
            s.delete();
            for (int k = $urandom_range(0, 3); k > 0; k--) s.push_back(8'($urandom_range(0, 8'hA4)));
            s.push_back(8'hA5);
            s.push_back(8'($urandom));
            cnt = $urandom_range(1, 6);
            s.push_back(8'(cnt));
            for (int k = 0; k < 2 * cnt; k++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            begin
                int sp = 0;
                while (s[sp] != 8'hA5) sp++;
                s.push_back(xor_sum(s, sp + 1));
            end
`endif
            send_stream(s, 1'b1);
            repeat (2) step();
            model_run(s);
            check_model($sformatf("rnd%0d", it));
        end

        // Reload after the HI byte of word 2.
        pulse_reload();
        log_a.delete();
        log_d.delete();
        s = '{8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_stream(s, 1'b0);
        pulse_reload();
        repeat (2) step();
        chk_eq("reload_nwrites", log_a.size(), 1);
        chk_eq("reload_cpu_rst_n", cpu_rst_n, 1'b0);
        chk_eq("reload_start_pc_held", start_pc, 8'h10);
        chk_eq("reload_in_ready", in_ready, 1'b1);
        chk_eq("reload_busy", busy, 1'b0);
        log_a.delete();
        log_d.delete();
        send_vec(vecs[3]);
        repeat (2) step();
        chk_eq("reload_fresh_nwrites", log_a.size(), 1);
        if (log_a.size() > 0) begin
            chk_eq("reload_fresh_addr", log_a[0], 8'h3C);
            chk_eq("reload_fresh_data", log_d[0], 16'hBEEF);
        end
        chk_eq("reload_fresh_cpu_rst_n", cpu_rst_n, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum.
        pulse_reload();
        log_a.delete();
        log_d.delete();
        v = vecs[0];
        for (int i = 0; i < int'(v.len); i++) send_byte(v.b[int'(v.len) - 1 - i], 1'b0);
        send_byte(8'h53, 1'b0);
        repeat (2) step();
        chk_eq("bad_err", err, 1'b1);
        chk_eq("bad_cpu_rst_n", cpu_rst_n, 1'b0);
        chk_eq("bad_in_ready", in_ready, 1'b0);
        chk_eq("bad_nwrites", log_a.size(), 2);
        pulse_reload();
        chk_eq("bad_reload_err", err, 1'b0);
        chk_eq("bad_reload_in_ready", in_ready, 1'b1);
`endif

        // Asynchronous reset in the middle of a frame.
        pulse_reload();
        s = '{8'hA5, 8'h42, 8'h03, 8'h11};
        send_stream(s, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_start_pc", start_pc, 8'h00);
        chk_eq("arst_busy", busy, 1'b0);
        chk_eq("arst_cpu_rst_n", cpu_rst_n, 1'b0);
        chk_eq("arst_w_en", ram_w_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_eq("arst_in_ready", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
